spi_cmd_seq: RTL and testbench
==============================

SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

Interface
REQ-001 SHALL have parameter SPI_MAXLEN, default 32, the maximum SCLK count per transaction and the data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the entry count of each of the command and response FIFOs (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, the clk cycles allowed per driver handshake phase.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have port sresetn  in  1  reset, synchronous and active-high despite the name.
REQ-006 SHALL have port cmd_valid  in  1  host command valid.
REQ-007 SHALL have port cmd_ready  out  1  command FIFO not full.
REQ-008 SHALL have port cmd_nclks  in  $clog2(SPI_MAXLEN)+1  requested SCLK count.
REQ-009 SHALL have port cmd_data  in  SPI_MAXLEN  MOSI payload, MSB-aligned to bit cmd_nclks-1.
REQ-010 SHALL have port rsp_valid  out  1  response FIFO not empty.
REQ-011 SHALL have port rsp_ready  in  1  host accepts response.
REQ-012 SHALL have port rsp_data  out  SPI_MAXLEN  captured MISO word.
REQ-013 SHALL have port rsp_err  out  1  response error flag (illegal length or timeout).
REQ-014 SHALL have port start_cmd  out  1  to spi_drv.
REQ-015 SHALL have port n_clks  out  $clog2(SPI_MAXLEN)+1  to spi_drv.
REQ-016 SHALL have port tx_data  out  SPI_MAXLEN  to spi_drv.
REQ-017 SHALL have port spi_drv_rdy  in  1  from spi_drv.
REQ-018 SHALL have port rx_miso  in  SPI_MAXLEN  from spi_drv.
REQ-019 SHALL have port busy  out  1  high whenever the FSM is not IDLE or the command FIFO is non-empty.

Function
REQ-020 SHALL push {cmd_nclks, cmd_data} into the command FIFO on every cycle where cmd_valid && cmd_ready; cmd_ready SHALL equal !full, with no same-cycle pop credit.
REQ-021 SHALL implement FSM states IDLE, START, WAIT_DONE, PUSH.
REQ-022 IDLE -> START SHALL occur when the command FIFO is non-empty, the response FIFO is not full, spi_drv_rdy==1, and the head entry has 1<=nclks<=SPI_MAXLEN; the head SHALL be popped into registered n_clks/tx_data in that same cycle.
REQ-023 If the head nclks is 0 or >SPI_MAXLEN and the response FIFO is not full, SHALL pop the head, push {data=0, err=1}, and remain in IDLE; the driver SHALL not be started.
REQ-024 start_cmd SHALL be 1 exactly while in START; n_clks/tx_data SHALL stay stable from entry to START until the FSM returns to IDLE.
REQ-025 START -> WAIT_DONE SHALL occur on the first cycle spi_drv_rdy is sampled 0 (ack).
REQ-026 WAIT_DONE -> PUSH SHALL occur on the first cycle spi_drv_rdy is sampled 1; rx_miso SHALL be captured in that cycle.
REQ-027 PUSH SHALL write {captured rx_miso, err=0} to the response FIFO and return to IDLE after 1 cycle.
REQ-028 A counter SHALL clear on entry to START and WAIT_DONE; on reaching TIMEOUT_CYCLES in either state, SHALL push {data=0, err=1} and go to IDLE, with REQ-022 blocking the next start until spi_drv_rdy==1.
REQ-029 The response FIFO SHALL allow a simultaneous push and pop when full; rsp_data/rsp_err SHALL show the head entry, first-word fall-through.
REQ-030 Command order SHALL be preserved: the k-th accepted command yields the k-th response.

Reset
REQ-031 While sresetn==1 at posedge: FSM IDLE, both FIFOs empty, counter 0, start_cmd=0, n_clks=0, tx_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=0, busy=0.
REQ-032 cmd_ready SHALL rise the first cycle after reset deasserts; reset mid-transaction SHALL discard all queued commands and responses.

Structure
REQ-033 Package spi_pkg SHALL hold the SPI_MAXLEN default, the state enum, and the cmd/rsp entry structs.
REQ-034 A sub-module sync_fifo (parameterised width/depth, full/empty) SHALL be instantiated twice.

Verification
REQ-035 Loopback spi_drv with MOSI tied to MISO; cmd nclks=32, data 0xC128ABE9 -> one start_cmd pulse, rsp_data 0xC128ABE9, rsp_err=0.
REQ-036 Back-to-back 0xB991FE65, 0xE08657BB, with rsp_ready held 0 -> both queued, then released in order, err=0.
REQ-037 cmd nclks=0, then nclks=33 -> no start_cmd, two responses with data 0 and err=1.
REQ-038 Driver model never drops rdy, TIMEOUT_CYCLES=16 -> start_cmd high 16 cycles, then response data 0, err=1.
REQ-039 Push 4 commands with rsp_ready=0 and FIFO_DEPTH=4 -> exactly 4 transactions, then stall; 5th command accepted while cmd_ready=1.
REQ-040 Assert sresetn during WAIT_DONE -> next cycle start_cmd=0, rsp_valid=0; no start until spi_drv_rdy returns to 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI command sequencer: FSM state encoding, default
// width, queue entry layouts and the transfer-length legality check.
package spi_pkg;

    localparam int SPI_MAXLEN_DEF = 32;
    localparam int NCLK_W_DEF     = $clog2(SPI_MAXLEN_DEF) + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_PUSH      = 2'd3
    } seq_state_e;

    // Entry layouts at the default width; the sequencer re-declares them
    // with its own SPI_MAXLEN so that non-default widths stay consistent.
    typedef struct packed {
        logic [NCLK_W_DEF-1:0]     nclks;
        logic [SPI_MAXLEN_DEF-1:0] data;
    } spi_cmd_t;

    typedef struct packed {
        logic [SPI_MAXLEN_DEF-1:0] data;
        logic                      err;
    } spi_rsp_t;

    function automatic logic nclks_ok(input int unsigned nclks, input int unsigned maxlen);
        return (nclks >= 32'd1) && (nclks <= maxlen);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. A push while full
// is accepted only when paired with a pop in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head entry; an empty FIFO reads as zero so stale storage never leaks out.
    always_comb begin
        if (empty_o) begin
            rdata_o = '0;
        end else begin
            rdata_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/spi_cmd_seq.sv
// Queues host SPI commands, hands them one at a time to an external spi_drv
// through a rdy/start handshake, and returns captured MISO words in order.
module spi_cmd_seq
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN     = SPI_MAXLEN_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(SPI_MAXLEN):0]   cmd_nclks,
    input  logic [SPI_MAXLEN-1:0]         cmd_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [SPI_MAXLEN-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          start_cmd,
    output logic [$clog2(SPI_MAXLEN):0]   n_clks,
    output logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic                          spi_drv_rdy,
    input  logic [SPI_MAXLEN-1:0]         rx_miso,
    output logic                          busy
);

    localparam int NW = $clog2(SPI_MAXLEN) + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [NW-1:0]         nclks;
        logic [SPI_MAXLEN-1:0] data;
    } cmd_entry_t;

    typedef struct packed {
        logic [SPI_MAXLEN-1:0] data;
        logic                  err;
    } rsp_entry_t;

    seq_state_e            state_q, state_d;
    logic [NW-1:0]         n_clks_q, n_clks_d;
    logic [SPI_MAXLEN-1:0] tx_data_q, tx_data_d;
    logic [SPI_MAXLEN-1:0] rx_q, rx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  start_q;
    logic                  ready_q;

    cmd_entry_t cmd_wdata_s, cmd_head_s;
    rsp_entry_t rsp_wdata_s, rsp_head_s;
    logic       cmd_push_s, cmd_pop_s, cmd_full_s, cmd_empty_s;
    logic       rsp_push_s, rsp_pop_s, rsp_full_s, rsp_empty_s;
    logic       head_ok_s;
    logic       tmo_s;

    assign cmd_ready   = ready_q && !cmd_full_s;
    assign cmd_push_s  = cmd_valid && cmd_ready;
    assign cmd_wdata_s = {cmd_nclks, cmd_data};

    assign rsp_valid = !rsp_empty_s;
    assign rsp_pop_s = rsp_ready && rsp_valid;
    assign rsp_data  = rsp_head_s.data;
    assign rsp_err   = rsp_head_s.err;

    assign start_cmd = start_q;
    assign n_clks    = n_clks_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != ST_IDLE) || !cmd_empty_s;

    assign head_ok_s = nclks_ok(int'(cmd_head_s.nclks), SPI_MAXLEN);
    assign tmo_s     = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    sync_fifo #(
        .WIDTH (NW + SPI_MAXLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .srst    (sresetn),
        .push_i  (cmd_push_s),
        .pop_i   (cmd_pop_s),
        .wdata_i (cmd_wdata_s),
        .rdata_o (cmd_head_s),
        .full_o  (cmd_full_s),
        .empty_o (cmd_empty_s)
    );

    sync_fifo #(
        .WIDTH (SPI_MAXLEN + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .srst    (sresetn),
        .push_i  (rsp_push_s),
        .pop_i   (rsp_pop_s),
        .wdata_i (rsp_wdata_s),
        .rdata_o (rsp_head_s),
        .full_o  (rsp_full_s),
        .empty_o (rsp_empty_s)
    );

    // Next-state, queue handshakes and response formation.
    always_comb begin
        state_d     = state_q;
        n_clks_d    = n_clks_q;
        tx_data_d   = tx_data_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        cmd_pop_s   = 1'b0;
        rsp_push_s  = 1'b0;
        rsp_wdata_s = '0;

        case (state_q)
            ST_IDLE: begin
                // A start is only issued with room reserved for its response.
                if (!cmd_empty_s && !rsp_full_s) begin
                    if (!head_ok_s) begin
                        cmd_pop_s       = 1'b1;
                        rsp_push_s      = 1'b1;
                        rsp_wdata_s.err = 1'b1;
                    end else if (spi_drv_rdy) begin
                        cmd_pop_s = 1'b1;
                        n_clks_d  = cmd_head_s.nclks;
                        tx_data_d = cmd_head_s.data;
                        cnt_d     = '0;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!spi_drv_rdy) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else if (tmo_s) begin
                    rsp_push_s      = 1'b1;
                    rsp_wdata_s.err = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (spi_drv_rdy) begin
                    rx_d    = rx_miso;
                    state_d = ST_PUSH;
                end else if (tmo_s) begin
                    rsp_push_s      = 1'b1;
                    rsp_wdata_s.err = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PUSH: begin
                rsp_push_s       = 1'b1;
                rsp_wdata_s.data = rx_q;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered driver-facing outputs.
    always_ff @(posedge clk) begin
        if (sresetn) begin
            state_q   <= ST_IDLE;
            n_clks_q  <= '0;
            tx_data_q <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_clks_q  <= n_clks_d;
            tx_data_q <= tx_data_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            start_q   <= (state_d == ST_START);
            ready_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq with a loopback spi_drv model whose
// behaviour (normal, never-acknowledging, acknowledge-then-hang) is selectable.
module tb_spi_cmd_seq;

    localparam int ML  = 32;
    localparam int NW  = 6;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          sresetn, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic          start_cmd, spi_drv_rdy, busy;
    logic [NW-1:0] cmd_nclks, n_clks;
    logic [ML-1:0] cmd_data, rsp_data, tx_data, rx_miso;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            start_pulses = 0;
    int            start_cycles = 0;
    logic          start_prev = 1'b0;
    int            drv_mode = 0;
    int            drv_cnt  = 0;
    logic [ML-1:0] drv_word;

    always #5 clk = ~clk;

    spi_cmd_seq #(
        .SPI_MAXLEN     (ML),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .sresetn     (sresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_nclks   (cmd_nclks),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .start_cmd   (start_cmd),
        .n_clks      (n_clks),
        .tx_data     (tx_data),
        .spi_drv_rdy (spi_drv_rdy),
        .rx_miso     (rx_miso),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ML-1:0] loop_word(input logic [ML-1:0] d, input logic [NW-1:0] n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return d & m[ML-1:0];
    endfunction

    // start_cmd pulse and high-cycle monitor
    initial begin
        forever begin
            @(negedge clk);
            if (start_cmd) start_cycles++;
            if (start_cmd && !start_prev) start_pulses++;
            start_prev = start_cmd;
        end
    end

    // spi_drv model: 0 loopback, 1 never acks, 2 acks then hangs
    initial begin
        forever begin
            @(negedge clk);
            if (drv_mode == 0) begin
                if (drv_cnt > 0) begin
                    drv_cnt--;
                    if (drv_cnt == 0) begin
                        rx_miso     = drv_word;
                        spi_drv_rdy = 1'b1;
                    end
                end else if (start_cmd && spi_drv_rdy) begin
                    drv_word    = loop_word(tx_data, n_clks);
                    spi_drv_rdy = 1'b0;
                    drv_cnt     = 4;
                end
            end else if (drv_mode == 2) begin
                if (start_cmd && spi_drv_rdy) spi_drv_rdy = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [NW-1:0] n, input logic [ML-1:0] d);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 64'd1);
        cmd_valid = 1'b1;
        cmd_nclks = n;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [ML-1:0] exp_d, input logic exp_e);
        int t = 0;
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, rsp_valid, 64'd1);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_err"}, rsp_err, exp_e);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_idle"}, busy, 64'd0);
    endtask

    initial begin
        int s0;
        sresetn     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_nclks   = 6'd0;
        cmd_data    = 32'd0;
        rsp_ready   = 1'b0;
        spi_drv_rdy = 1'b1;
        rx_miso     = 32'd0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_start", start_cmd, 64'd0);
        chk("rst_nclks", n_clks, 64'd0);
        chk("rst_tx", tx_data, 64'd0);
        chk("rst_rsp_valid", rsp_valid, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_err", rsp_err, 64'd0);
        chk("rst_cmd_ready", cmd_ready, 64'd0);
        chk("rst_busy", busy, 64'd0);
        sresetn = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 64'd1);

        // single loopback transfer
        s0 = start_pulses;
        send_cmd(6'd32, 32'hC128ABE9);
        get_rsp("loop", 32'hC128ABE9, 1'b0);
        wait_idle("loop");
        chk("loop_pulses", start_pulses - s0, 64'd1);

        // back-to-back with responses held
        send_cmd(6'd32, 32'hB991FE65);
        send_cmd(6'd32, 32'hE08657BB);
        wait_idle("b2b");
        chk("b2b_held", rsp_valid, 64'd1);
        get_rsp("b2b_0", 32'hB991FE65, 1'b0);
        get_rsp("b2b_1", 32'hE08657BB, 1'b0);

        // illegal lengths never reach the driver
        s0 = start_pulses;
        send_cmd(6'd0, 32'h12345678);
        send_cmd(6'd33, 32'h87654321);
        wait_idle("bad");
        chk("bad_pulses", start_pulses - s0, 64'd0);
        get_rsp("bad_0", 32'h0, 1'b1);
        get_rsp("bad_33", 32'h0, 1'b1);

        // driver never acknowledges: timeout in START
        drv_mode = 1;
        s0 = start_cycles;
        send_cmd(6'd32, 32'h5A5A5A5A);
        wait_idle("tmo");
        chk("tmo_start_cycles", start_cycles - s0, 64'd16);
        get_rsp("tmo", 32'h0, 1'b1);
        chk("tmo_nclks_hold", n_clks, 64'd32);
        chk("tmo_tx_hold", tx_data, 64'h5A5A5A5A);
        drv_mode = 0;

        // response FIFO fills after four transfers, fifth command stalls
        s0 = start_pulses;
        send_cmd(6'd32, 32'h11111111);
        send_cmd(6'd8,  32'h123456A5);
        send_cmd(6'd32, 32'h80000001);
        send_cmd(6'd16, 32'h0F0F0F0F);
        repeat (60) @(negedge clk);
        chk("full_pulses", start_pulses - s0, 64'd4);
        chk("full_busy", busy, 64'd0);
        chk("full_cmd_ready", cmd_ready, 64'd1);
        send_cmd(6'd32, 32'hDEADBEEF);
        repeat (20) @(negedge clk);
        chk("stall_pulses", start_pulses - s0, 64'd4);
        chk("stall_busy", busy, 64'd1);
        get_rsp("full_0", 32'h11111111, 1'b0);
        get_rsp("full_1", 32'h000000A5, 1'b0);
        get_rsp("full_2", 32'h80000001, 1'b0);
        get_rsp("full_3", 32'h00000F0F, 1'b0);
        get_rsp("full_4", 32'hDEADBEEF, 1'b0);
        wait_idle("full");

        // reset in WAIT_DONE discards the in-flight and queued commands
        drv_mode = 2;
        s0 = start_pulses;
        send_cmd(6'd32, 32'hAAAA5555);
        send_cmd(6'd32, 32'h5555AAAA);
        begin
            int t = 0;
            while (start_pulses == s0 && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        repeat (3) @(negedge clk);
        chk("wd_busy", busy, 64'd1);
        chk("wd_rdy_low", spi_drv_rdy, 64'd0);
        sresetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_start", start_cmd, 64'd0);
        chk("mid_rst_rsp_valid", rsp_valid, 64'd0);
        chk("mid_rst_busy", busy, 64'd0);
        sresetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_ready", cmd_ready, 64'd1);
        s0 = start_pulses;
        send_cmd(6'd32, 32'h0BADF00D);
        repeat (6) @(negedge clk);
        chk("rdy_low_no_start", start_pulses - s0, 64'd0);
        chk("rdy_low_no_rsp", rsp_valid, 64'd0);
        drv_mode    = 0;
        spi_drv_rdy = 1'b1;
        get_rsp("after_rst", 32'h0BADF00D, 1'b0);
        wait_idle("after_rst");
        chk("after_rst_pulses", start_pulses - s0, 64'd1);
        chk("after_rst_empty", rsp_valid, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
